// File: rtl/axi_read_arbiter_if.sv
// Bundle between the two read requesters (fetch, dcache), the arbiter and the AXI4 AR/R channel.
// The master modport is the arbiter's view; slave is the requester/interconnect side.
interface axi_read_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*ADDR_W-1:0] req_addr;
   logic [15:0]         req_len;
   logic [1:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_data;
   logic                rsp_last;
   logic                rsp_err;
   logic                m_axi_arready;
   logic                m_axi_arvalid;
   logic [ADDR_W-1:0]   m_axi_araddr;
   logic [7:0]          m_axi_arlen;
   logic [2:0]          m_axi_arsize;
   logic [1:0]          m_axi_arburst;
   logic [3:0]          m_axi_arcache;
   logic [5:0]          m_axi_arid;
   logic                m_axi_rready;
   logic                m_axi_rvalid;
   logic [DATA_W-1:0]   m_axi_rdata;
   logic [1:0]          m_axi_rresp;
   logic                m_axi_rlast;
   logic [5:0]          m_axi_rid;

   modport master (
      input  req_valid, req_addr, req_len,
      input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
      output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
      output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
      output m_axi_arcache, m_axi_arid, m_axi_rready
   );

   modport slave (
      output req_valid, req_addr, req_len,
      output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
      input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
      input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
      input  m_axi_arcache, m_axi_arid, m_axi_rready
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between fetch (0) and dcache (1) misses.
// One burst in flight; R beats are registered and steered back to the owning requester.
module axi_read_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input logic                clk,
   input logic                rst,
   axi_read_arbiter_if.master bus
);

   localparam logic [2:0] ArSize = 3'($clog2(DATA_W / 8));

   typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              rr_last_q, rr_last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic              past_len_q, past_len_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_last_q, rsp_last_d;
   logic              rsp_err_q, rsp_err_d;

   logic              win;
   logic              len_mismatch;
   logic [1:0]        grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         rr_last_q   <= 1'b1;
         addr_q      <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         past_len_q  <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_last_q   <= rr_last_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         past_len_q  <= past_len_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_last_q  <= rsp_last_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_last_d   = rr_last_q;
      addr_d      = addr_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      past_len_d  = past_len_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = 1'b0;
      rsp_err_d   = 1'b0;
      grant       = '0;

      // On a tie the requester that did not win last time goes next.
      win = (&bus.req_valid) ? ~rr_last_q : bus.req_valid[1];
      // past_len_q keeps the error asserted once the burst has overrun, even at a saturated count.
      len_mismatch = bus.m_axi_rlast ? ((beat_cnt_q != len_q) || past_len_q)
                                     : (beat_cnt_q >= len_q);

      unique case (state_q)
         StIdle: begin
            if (|bus.req_valid) begin
               grant     = win ? 2'b10 : 2'b01;
               owner_d   = win;
               rr_last_d = win;
               addr_d    = win ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
               len_d     = win ? bus.req_len[15:8] : bus.req_len[7:0];
               state_d   = StAr;
            end
         end
         StAr: begin
            if (bus.m_axi_arready) begin
               beat_cnt_d = '0;
               past_len_d = 1'b0;
               state_d    = StR;
            end
         end
         StR: begin
            if (bus.m_axi_rvalid) begin
               rsp_valid_d = owner_q ? 2'b10 : 2'b01;
               rsp_data_d  = bus.m_axi_rdata;
               rsp_last_d  = bus.m_axi_rlast;
               rsp_err_d   = (bus.m_axi_rresp != 2'b00) ||
                             (bus.m_axi_rid != {5'b0, owner_q}) || len_mismatch;
               if (beat_cnt_q != 8'hff) beat_cnt_d = beat_cnt_q + 8'd1;
               if (!bus.m_axi_rlast && (beat_cnt_q >= len_q)) past_len_d = 1'b1;
               if (bus.m_axi_rlast) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.req_ready     = grant & {2{~rst}};
      bus.rsp_valid     = rsp_valid_q;
      bus.rsp_data      = rsp_data_q;
      bus.rsp_last      = rsp_last_q;
      bus.rsp_err       = rsp_err_q;
      bus.m_axi_arvalid = (state_q == StAr);
      bus.m_axi_araddr  = addr_q;
      bus.m_axi_arlen   = len_q;
      bus.m_axi_arsize  = ArSize;
      bus.m_axi_arburst = 2'b01;
      bus.m_axi_arcache = 4'b0011;
      bus.m_axi_arid    = {5'b0, owner_q};
      bus.m_axi_rready  = (state_q == StR);
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a table of bursts with hand-computed grants and per-beat
// error masks, plus hand-written sequences for IDLE-time rvalid and mid-burst reset.
module tb_axi_read_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  req;
      logic [31:0] addr0;
      logic [7:0]  len0;
      logic [31:0] addr1;
      logic [7:0]  len1;
      int          nbeats;
      int          ar_delay;
      int          bad_resp_beat;
      int          bad_rid_beat;
      logic [1:0]  exp_grant;
      logic [15:0] exp_err;
   } vec_t;

   vec_t vecs[11];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic        own;
      logic [31:0] ea;
      logic [7:0]  el;
      own = v.exp_grant[1];
      ea  = own ? v.addr1 : v.addr0;
      el  = own ? v.len1 : v.len0;
      bus.req_valid = v.req;
      bus.req_addr  = {v.addr1, v.addr0};
      bus.req_len   = {v.len1, v.len0};
      #1;
      chk("grant", 64'(bus.req_ready), 64'(v.exp_grant));
      @(negedge clk);
      bus.req_valid = v.req & ~v.exp_grant;
      chk("ar_issue", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arid,
                       bus.req_ready}, {1'b1, ea, el, 5'b0, own, 2'b00});
      for (int i = 0; i < v.ar_delay; i++) begin
         @(negedge clk);
         chk("ar_hold", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.req_ready},
             {1'b1, ea, el, 2'b00});
      end
      bus.m_axi_arready = 1'b1;
      @(negedge clk);
      bus.m_axi_arready = 1'b0;
      chk("r_phase", {bus.m_axi_rready, bus.m_axi_arvalid}, 2'b10);
      for (int b = 1; b <= v.nbeats; b++) begin
         bus.m_axi_rvalid = 1'b1;
         bus.m_axi_rdata  = {ea[15:0], 16'(b)};
         bus.m_axi_rlast  = (b == v.nbeats);
         bus.m_axi_rresp  = (b == v.bad_resp_beat) ? 2'b10 : 2'b00;
         bus.m_axi_rid    = {5'b0, (b == v.bad_rid_beat) ? ~own : own};
         @(negedge clk);
         chk("rsp_beat", {bus.rsp_valid, bus.rsp_data, bus.rsp_last},
             {(own ? 2'b10 : 2'b01), ea[15:0], 16'(b), (b == v.nbeats)});
         chk("rsp_err", 64'(bus.rsp_err), 64'(v.exp_err[b-1]));
      end
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rlast  = 1'b0;
      bus.req_valid    = 2'b00;
      @(negedge clk);
      chk("back_idle", {bus.rsp_valid, bus.m_axi_rready, bus.m_axi_arvalid}, 4'b0000);
   endtask

   initial begin
      //            req    addr0        len0  addr1        len1  nb dly rsp rid grant  err
      vecs[0]  = '{2'b11, 32'h0000_2000, 8'd1, 32'h0000_3000, 8'd2, 2, 0, 0, 0, 2'b01, 16'h0};
      vecs[1]  = '{2'b11, 32'h0000_2000, 8'd1, 32'h0000_3000, 8'd2, 3, 0, 0, 0, 2'b10, 16'h0};
      vecs[2]  = '{2'b11, 32'h0000_2040, 8'd0, 32'h0000_3040, 8'd0, 1, 0, 0, 0, 2'b01, 16'h0};
      vecs[3]  = '{2'b11, 32'h0000_2040, 8'd0, 32'h0000_3040, 8'd0, 1, 0, 0, 0, 2'b10, 16'h0};
      vecs[4]  = '{2'b01, 32'h0000_1000, 8'd3, 32'h0000_0000, 8'd0, 4, 0, 0, 0, 2'b01, 16'h0};
      vecs[5]  = '{2'b10, 32'h0000_0000, 8'd0, 32'h0000_4000, 8'd1, 2, 5, 0, 0, 2'b10, 16'h0};
      vecs[6]  = '{2'b01, 32'h0000_5000, 8'd3, 32'h0000_0000, 8'd0, 2, 0, 0, 0, 2'b01, 16'h2};
      vecs[7]  = '{2'b01, 32'h0000_6000, 8'd1, 32'h0000_0000, 8'd0, 4, 0, 0, 0, 2'b01, 16'he};
      vecs[8]  = '{2'b01, 32'h0000_7000, 8'd1, 32'h0000_0000, 8'd0, 2, 0, 1, 0, 2'b01, 16'h1};
      vecs[9]  = '{2'b01, 32'h0000_8000, 8'd0, 32'h0000_0000, 8'd0, 1, 0, 0, 1, 2'b01, 16'h1};
      vecs[10] = '{2'b10, 32'h0000_0000, 8'd0, 32'h0000_9000, 8'd1, 2, 0, 0, 2, 2'b10, 16'h2};

      bus.req_valid     = '0;
      bus.req_addr      = '0;
      bus.req_len       = '0;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rvalid  = 1'b0;
      bus.m_axi_rdata   = '0;
      bus.m_axi_rresp   = '0;
      bus.m_axi_rlast   = 1'b0;
      bus.m_axi_rid     = '0;

      @(negedge clk);
      @(negedge clk);
      chk("reset_state", {bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.rsp_err,
                          bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_araddr, bus.m_axi_arlen},
          64'h0);
      chk("ar_consts", {bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arcache},
          {3'd2, 2'b01, 4'b0011});
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stray rvalid while idle must be ignored.
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rlast  = 1'b1;
      #1;
      chk("idle_rready", 64'(bus.m_axi_rready), 64'd0);
      @(negedge clk);
      chk("idle_no_rsp", 64'(bus.rsp_valid), 64'd0);
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rlast  = 1'b0;

      // Reset in the middle of a burst, then a tie must go to requester 0.
      bus.req_valid = 2'b01;
      bus.req_addr  = {32'h0, 32'h0000_a000};
      bus.req_len   = {8'd0, 8'd3};
      @(negedge clk);
      bus.req_valid     = 2'b00;
      bus.m_axi_arready = 1'b1;
      @(negedge clk);
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rvalid  = 1'b1;
      bus.m_axi_rdata   = 32'h1234_5678;
      bus.m_axi_rid     = 6'd0;
      @(negedge clk);
      chk("pre_reset_beat", {bus.rsp_valid, bus.m_axi_rready}, 3'b011);
      bus.req_valid = 2'b11;
      bus.req_addr  = {32'h0000_c000, 32'h0000_b000};
      bus.req_len   = {8'd2, 8'd1};
      rst = 1'b1;
      #1;
      chk("mid_reset", {bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.rsp_data,
                        bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_araddr, bus.m_axi_arlen},
          64'h0);
      bus.m_axi_rvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_reset_grant", 64'(bus.req_ready), 64'(2'b01));
      @(negedge clk);
      bus.req_valid = 2'b00;
      chk("post_reset_ar", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arid},
          {1'b1, 32'h0000_b000, 8'd1, 6'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
